// File: rtl/learning_output_port_lookup.sv
// Learning MAC switch output-port lookup: parses the Ethernet header, looks up the destination
// in a 4-entry learned table, writes dst_port into tuser[31:24], and learns source MACs.
module learning_output_port_lookup #(
    parameter int C_AXIS_DATA_WIDTH  = 64,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int C_LUT_DEPTH        = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [31:0]                     lut_hit_count,
    output logic [31:0]                     lut_miss_count
);
    localparam int PTR_W = $clog2(C_LUT_DEPTH);

    typedef enum logic [1:0] {WORD0, WORD1, PAYLOAD} state_t;

    state_t state_q, state_d;

    logic                           m_tvalid_q, m_tlast_q;
    logic [C_AXIS_DATA_WIDTH-1:0]   m_tdata_q;
    logic [C_AXIS_DATA_WIDTH/8-1:0] m_tstrb_q;
    logic [C_AXIS_TUSER_WIDTH-1:0]  m_tuser_q, tuser_d;

    logic [47:0]            mac_q  [C_LUT_DEPTH];
    logic [7:0]             port_q [C_LUT_DEPTH];
    logic [C_LUT_DEPTH-1:0] vld_q;
    logic [PTR_W-1:0]       ptr_q;
    logic [31:0]            hit_q, miss_q;
    logic [15:0]            src_hi_q;
    logic [7:0]             src_port_q;

    logic        accept, lookup_en, learn_en;
    logic [47:0] dst_mac, learn_mac;
    logic [7:0]  src_port, lk_port, dst_port;
    logic        lk_hit, is_bcast, ln_hit;
    logic [PTR_W-1:0] ln_idx;

    assign s_axis_tready = ~m_tvalid_q | m_axis_tready;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign lookup_en     = accept && (state_q == WORD0);
    // Multicast source addresses (I/G bit set) are never learned.
    assign learn_en      = accept && (state_q == WORD1) && !src_hi_q[0];

    assign dst_mac   = s_axis_tdata[47:0];
    assign src_port  = s_axis_tuser[23:16];
    assign learn_mac = {s_axis_tdata[31:0], src_hi_q};
    assign is_bcast  = &dst_mac;

    always_comb begin
        lk_hit  = 1'b0;
        lk_port = 8'h00;
        ln_hit  = 1'b0;
        ln_idx  = '0;
        for (int i = 0; i < C_LUT_DEPTH; i++) begin
            if (!lk_hit && vld_q[i] && mac_q[i] == dst_mac) begin
                lk_hit  = 1'b1;
                lk_port = port_q[i];
            end
            if (!ln_hit && vld_q[i] && mac_q[i] == learn_mac) begin
                ln_hit = 1'b1;
                ln_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        dst_port = 8'h55 & ~src_port;
        if (!is_bcast && lk_hit)
            dst_port = (lk_port == src_port) ? 8'h00 : lk_port;
        tuser_d = s_axis_tuser;
        if (state_q == WORD0)
            tuser_d[31:24] = dst_port;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            case (state_q)
                WORD0:   state_d = s_axis_tlast ? WORD0 : WORD1;
                WORD1:   state_d = s_axis_tlast ? WORD0 : PAYLOAD;
                PAYLOAD: state_d = s_axis_tlast ? WORD0 : PAYLOAD;
                default: state_d = WORD0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WORD0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            hit_q      <= 32'd0;
            miss_q     <= 32'd0;
            vld_q      <= '0;
            ptr_q      <= '0;
        end else begin
            state_q <= state_d;
            if (s_axis_tready) begin
                m_tvalid_q <= s_axis_tvalid;
                m_tlast_q  <= s_axis_tlast;
            end
            if (lookup_en && !is_bcast) begin
                if (lk_hit) hit_q  <= hit_q + 32'd1;
                else        miss_q <= miss_q + 32'd1;
            end
            if (learn_en && !ln_hit) begin
                vld_q[ptr_q] <= 1'b1;
                ptr_q        <= ptr_q + 1'b1;
            end
        end
    end

    // Datapath and table contents need no reset: qualified by valid bits.
    always_ff @(posedge clk) begin
        if (s_axis_tready) begin
            m_tdata_q <= s_axis_tdata;
            m_tstrb_q <= s_axis_tstrb;
            m_tuser_q <= tuser_d;
        end
        if (lookup_en) begin
            src_hi_q   <= s_axis_tdata[63:48];
            src_port_q <= src_port;
        end
        if (learn_en) begin
            if (ln_hit) begin
                port_q[ln_idx] <= src_port_q;
            end else begin
                mac_q[ptr_q]  <= learn_mac;
                port_q[ptr_q] <= src_port_q;
            end
        end
    end

    assign m_axis_tdata   = m_tdata_q;
    assign m_axis_tstrb   = m_tstrb_q;
    assign m_axis_tuser   = m_tuser_q;
    assign m_axis_tvalid  = m_tvalid_q;
    assign m_axis_tlast   = m_tlast_q;
    assign lut_hit_count  = hit_q;
    assign lut_miss_count = miss_q;

endmodule
